// File: rtl/logic_axi4_stream_queue_pkg.sv
// Shared constants and types for the AXI4-Stream queue family.
package logic_axi4_stream_queue_pkg;
  typedef enum logic {
    QUEUE_CUT_THROUGH   = 1'b0,
    QUEUE_STORE_FORWARD = 1'b1
  } queue_mode_e;

  localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/logic_axi4_stream_if.sv
// AXI4-Stream bundle; rx is the sink side, tx the source side.
interface logic_axi4_stream_if #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tlast;

  modport rx (input tvalid, tdata, tuser, tlast, output tready);
  modport tx (output tvalid, tdata, tuser, tlast, input tready);
endinterface

// File: rtl/logic_axi4_stream_queue_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module logic_axi4_stream_queue_ram #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/logic_axi4_stream_queue_generic.sv
// AXI4-Stream queue: RAM body plus two-entry output stage, optional
// store-and-forward gating on tlast.
module logic_axi4_stream_queue_generic
  import logic_axi4_stream_queue_pkg::*;
#(
  parameter int CAPACITY      = 256,
  parameter int ADDRESS_WIDTH = $clog2(CAPACITY),
  parameter int PACKET_MODE   = 0,
  parameter int ALMOST_FULL   = CAPACITY - 2,
  parameter int DATA_WIDTH    = 8,
  parameter int USER_WIDTH    = 1
) (
  input  logic                   aclk,
  input  logic                   areset_n,
  logic_axi4_stream_if.rx        rx,
  logic_axi4_stream_if.tx        tx,
  output logic [ADDRESS_WIDTH:0] usedw,
  output logic [ADDRESS_WIDTH:0] packets,
  output logic                   almost_full
);
  localparam int            W   = DATA_WIDTH + USER_WIDTH + 1;
  localparam int            CW  = ADDRESS_WIDTH + 1;
  localparam logic [CW-1:0] CAP = CW'(CAPACITY);
  localparam logic [CW-1:0] AF  = CW'(ALMOST_FULL);
  localparam bit            PKT = (PACKET_MODE == int'(QUEUE_STORE_FORWARD));

  if (CAPACITY < 4 || (CAPACITY & (CAPACITY - 1)) != 0 || ALMOST_FULL < 1 ||
      ALMOST_FULL > CAPACITY || ADDRESS_WIDTH != $clog2(CAPACITY)) begin : g_drc
    $error("logic_axi4_stream_queue_generic: illegal CAPACITY/ALMOST_FULL/ADDRESS_WIDTH");
  end

  logic [W-1:0]                  rx_beat, ram_dout, head_beat;
  logic [ADDRESS_WIDTH-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                 used_q, used_d, pkt_q, pkt_d, ram_cnt_q, ram_cnt_d;
  logic                          rdy_q, rdy_d, af_q, af_d, fwd_q, fwd_d, rd_vld_q;
  logic [1:0]                    skid_cnt_q, skid_cnt_d;
  logic [SKID_DEPTH-1:0][W-1:0]  skid_q, skid_d;
  logic                          wr, rd, ram_re, head_vld, head_last, push, pop, push_idx;

  assign rx_beat   = {rx.tlast, rx.tuser, rx.tdata};
  assign wr        = rx.tvalid && rdy_q;
  assign rd        = tx.tvalid && tx.tready;

  // The RAM read register acts as an extra output slot, so a beat can leave
  // straight from it without first landing in the skid registers.
  assign head_vld  = (skid_cnt_q != 2'd0) || rd_vld_q;
  assign head_beat = (skid_cnt_q != 2'd0) ? skid_q[0] : ram_dout;
  assign head_last = head_beat[W-1];
  assign ram_re    = (ram_cnt_q != '0) &&
                     (({1'b0, skid_cnt_q} + {2'b00, rd_vld_q}) < 3'(SKID_DEPTH));

  assign rx.tready = rdy_q;
  assign tx.tvalid = head_vld && (!PKT || pkt_q != '0 || fwd_q);
  assign {tx.tlast, tx.tuser, tx.tdata} = head_beat;

  assign usedw       = used_q;
  assign packets     = pkt_q;
  assign almost_full = af_q;

  always_comb begin
    used_d    = used_q + CW'(wr) - CW'(rd);
    pkt_d     = pkt_q + CW'(wr && rx.tlast) - CW'(rd && head_last);
    ram_cnt_d = ram_cnt_q + CW'(wr) - CW'(ram_re);
    wr_ptr_d  = wr_ptr_q + ADDRESS_WIDTH'(wr);
    rd_ptr_d  = rd_ptr_q + ADDRESS_WIDTH'(ram_re);
    rdy_d     = used_d < CAP;
    af_d      = used_d >= AF;
    // Full with no complete packet means an oversize packet: let it stream.
    fwd_d     = PKT && ((fwd_q && !(rd && head_last)) || (used_q == CAP && pkt_q == '0));
  end

  always_comb begin
    skid_d     = skid_q;
    pop        = rd && (skid_cnt_q != 2'd0);
    push       = rd_vld_q && !(rd && skid_cnt_q == 2'd0);
    push_idx   = skid_cnt_q[0] ^ pop;
    if (pop)  skid_d[0] = skid_q[1];
    if (push) skid_d[push_idx] = ram_dout;
    skid_cnt_d = skid_cnt_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      used_q     <= '0;
      pkt_q      <= '0;
      ram_cnt_q  <= '0;
      rdy_q      <= 1'b0;
      af_q       <= 1'b0;
      fwd_q      <= 1'b0;
      rd_vld_q   <= 1'b0;
      skid_cnt_q <= 2'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      used_q     <= used_d;
      pkt_q      <= pkt_d;
      ram_cnt_q  <= ram_cnt_d;
      rdy_q      <= rdy_d;
      af_q       <= af_d;
      fwd_q      <= fwd_d;
      rd_vld_q   <= ram_re;
      skid_cnt_q <= skid_cnt_d;
    end
  end

  always_ff @(posedge aclk) skid_q <= skid_d;

  logic_axi4_stream_queue_ram #(.WIDTH(W), .DEPTH(2 ** ADDRESS_WIDTH)) u_ram (
    .clk_i   (aclk),
    .we_i    (wr),
    .waddr_i (wr_ptr_q),
    .wdata_i (rx_beat),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_dout)
  );
endmodule

// File: tb/tb_logic_axi4_stream_queue_generic.sv
// Bench for the stream queue: cut-through (a) and packet-mode (b) instances
// side by side, scoreboarded against the beats actually accepted.
module tb_logic_axi4_stream_queue_generic;
  localparam int CAP = 8, AFT = 6, DW = 8, UW = 2, BW = DW + UW + 1;
  typedef logic [BW-1:0] beat_t;

  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  always #5 aclk = ~aclk;

  logic_axi4_stream_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) ra(), ta(), rb(), tb();
  logic [3:0] used_a, pk_a, used_b, pk_b;
  logic       af_a, af_b;

  logic_axi4_stream_queue_generic #(.CAPACITY(CAP), .PACKET_MODE(0), .ALMOST_FULL(AFT),
    .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut_a (
    .aclk(aclk), .areset_n(areset_n), .rx(ra), .tx(ta),
    .usedw(used_a), .packets(pk_a), .almost_full(af_a));

  logic_axi4_stream_queue_generic #(.CAPACITY(CAP), .PACKET_MODE(1), .ALMOST_FULL(AFT),
    .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut_b (
    .aclk(aclk), .areset_n(areset_n), .rx(rb), .tx(tb),
    .usedw(used_b), .packets(pk_b), .almost_full(af_b));

  int    checks = 0, failures = 0;
  beat_t sba[$], sbb[$];
  int    m_used_a = 0, m_pk_a = 0, m_used_b = 0, m_pk_b = 0, max_a = 0;
  bit    live = 0, hold_a = 0, hold_b = 0, wr_a, rd_a, wr_b, rd_b;
  beat_t hb_a, hb_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: settle, score handshakes and status against the model, advance.
  task automatic step();
    beat_t oa, ob;
    #1;
    oa = {ta.tlast, ta.tuser, ta.tdata};
    ob = {tb.tlast, tb.tuser, tb.tdata};
    wr_a = ra.tvalid && ra.tready;  rd_a = ta.tvalid && ta.tready;
    wr_b = rb.tvalid && rb.tready;  rd_b = tb.tvalid && tb.tready;
    chk("a_usedw",   32'(used_a),    32'(m_used_a));
    chk("a_packets", 32'(pk_a),      32'(m_pk_a));
    chk("a_tready",  32'(ra.tready), 32'(live && m_used_a < CAP));
    chk("a_afull",   32'(af_a),      32'(m_used_a >= AFT));
    chk("b_usedw",   32'(used_b),    32'(m_used_b));
    chk("b_packets", 32'(pk_b),      32'(m_pk_b));
    chk("b_tready",  32'(rb.tready), 32'(live && m_used_b < CAP));
    chk("b_afull",   32'(af_b),      32'(m_used_b >= AFT));
    if (hold_a) chk("a_stable", 32'({ta.tvalid, oa}), 32'({1'b1, hb_a}));
    if (hold_b) chk("b_stable", 32'({tb.tvalid, ob}), 32'({1'b1, hb_b}));
    hold_a = ta.tvalid && !ta.tready;  hb_a = oa;
    hold_b = tb.tvalid && !tb.tready;  hb_b = ob;
    if (rd_a) begin
      if (sba.size() == 0) chk("a_extra_beat", 32'(rd_a), 32'd0);
      else chk("a_beat", 32'(oa), 32'(sba.pop_front()));
    end
    if (rd_b) begin
      if (sbb.size() == 0) chk("b_extra_beat", 32'(rd_b), 32'd0);
      else chk("b_beat", 32'(ob), 32'(sbb.pop_front()));
    end
    if (wr_a) sba.push_back({ra.tlast, ra.tuser, ra.tdata});
    if (wr_b) sbb.push_back({rb.tlast, rb.tuser, rb.tdata});
    m_used_a += int'(wr_a) - int'(rd_a);
    m_pk_a   += int'(wr_a && ra.tlast) - int'(rd_a && ta.tlast);
    m_used_b += int'(wr_b) - int'(rd_b);
    m_pk_b   += int'(wr_b && rb.tlast) - int'(rd_b && tb.tlast);
    if (int'(used_a) > max_a) max_a = int'(used_a);
    @(posedge aclk);
    if (areset_n) live = 1;
    @(negedge aclk);
  endtask

  task automatic drain();
    int g = 0;
    ta.tready = 1'b1;
    tb.tready = 1'b1;
    while ((sba.size() > 0 || sbb.size() > 0) && g < 200) begin
      step();
      g++;
    end
    chk("drain_left", 32'(sba.size() + sbb.size()), 32'd0);
  endtask

  initial begin
    int sent, g, streak, best;
    bit saw, expon;
    ra.tvalid = 0; ra.tdata = '0; ra.tuser = '0; ra.tlast = 0; ta.tready = 0;
    rb.tvalid = 0; rb.tdata = '0; rb.tuser = '0; rb.tlast = 0; tb.tready = 0;

    // Reset state
    @(negedge aclk);
    chk("rst_a_tready", 32'(ra.tready), 32'd0);
    chk("rst_a_tvalid", 32'(ta.tvalid), 32'd0);
    chk("rst_b_tready", 32'(rb.tready), 32'd0);
    chk("rst_b_tvalid", 32'(tb.tvalid), 32'd0);
    step(); step();
    areset_n = 1'b1;
    step();
    chk("release_tready", 32'(ra.tready), 32'd1);

    // Single beat latency, cut-through
    ta.tready = 1'b1;
    ra.tvalid = 1; ra.tdata = 8'hA5; ra.tuser = 2'd1; ra.tlast = 1;
    step();
    ra.tvalid = 0;
    chk("t1_n1_tvalid", 32'(ta.tvalid), 32'd0);
    chk("t1_n1_usedw",  32'(used_a),    32'd1);
    step();
    chk("t1_n2_tvalid", 32'(ta.tvalid), 32'd1);
    chk("t1_n2_tdata",  32'(ta.tdata),  32'hA5);
    step();
    chk("t1_usedw0",    32'(used_a),    32'd0);

    // Fill to capacity, almost_full threshold, one read reopens tready
    ta.tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ra.tvalid = 1; ra.tdata = 8'(8'h10 + i); ra.tuser = UW'(i); ra.tlast = (i == 3 || i == 7);
      step();
      chk("t2_usedw", 32'(used_a), 32'(i + 1));
      chk("t2_afull", 32'(af_a),   32'(i >= 5));
    end
    chk("t2_full_tready", 32'(ra.tready), 32'd0);
    chk("t2_packets",     32'(pk_a),      32'd2);
    ra.tdata = 8'hEE; ra.tuser = 2'd3; ra.tlast = 0;
    ta.tready = 1'b1;
    step();
    ta.tready = 1'b0;
    chk("t2_tready_back", 32'(ra.tready), 32'd1);
    chk("t2_usedw7",      32'(used_a),    32'd7);
    step();
    ra.tvalid = 0;
    drain();

    // Random throttling, 1000 beats
    sent = 0; g = 0; max_a = 0;
    while ((sent < 1000 || sba.size() > 0) && g < 20000) begin
      if (!ra.tvalid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        ra.tvalid = 1; ra.tdata = 8'($urandom); ra.tuser = UW'($urandom);
        ra.tlast = ($urandom_range(0, 7) == 0);
      end
      ta.tready = ($urandom_range(0, 2) != 0);
      step();
      g++;
      if (wr_a) begin sent++; ra.tvalid = 0; end
    end
    ra.tvalid = 0;
    chk("t3_sent",     32'(sent),        32'd1000);
    chk("t3_sb_empty", 32'(sba.size()),  32'd0);
    chk("t3_max_used", 32'(max_a <= CAP), 32'd1);
    drain();

    // Continuous stream: one beat per cycle without bubbles
    ta.tready = 1'b1;
    sent = 0; g = 0; streak = 0; best = 0;
    while ((sent < 50 || sba.size() > 0) && g < 300) begin
      if (sent < 50) begin
        ra.tvalid = 1; ra.tdata = 8'(sent); ra.tuser = UW'(sent); ra.tlast = (sent == 49);
      end else ra.tvalid = 0;
      step();
      g++;
      if (wr_a) sent++;
      if (rd_a) streak++; else streak = 0;
      if (streak > best) best = streak;
    end
    ra.tvalid = 0;
    chk("t3_streak", 32'(best), 32'd50);
    ta.tready = 1'b0;

    // Packet mode: gated until tlast is stored
    tb.tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t4_gate", 32'(tb.tvalid), 32'd0);
      rb.tvalid = 1; rb.tdata = 8'(8'h31 + k); rb.tuser = UW'(k); rb.tlast = (k == 2);
      step();
      rb.tvalid = 0;
      if (k < 2) for (int j = 0; j < 2; j++) begin
        chk("t4_gate", 32'(tb.tvalid), 32'd0);
        step();
      end
    end
    chk("t4_tvalid_next", 32'(tb.tvalid), 32'd1);
    chk("t4_packets1",    32'(pk_b),      32'd1);
    drain();
    chk("t4_packets0",    32'(pk_b),      32'd0);

    // Packet mode: oversize packet streams once the queue fills
    tb.tready = 1'b1;
    sent = 0; g = 0; saw = 0; expon = 0;
    while ((sent < 12 || sbb.size() > 0) && g < 300) begin
      if (!rb.tvalid && sent < 12) begin
        rb.tvalid = 1; rb.tdata = 8'(8'h50 + sent); rb.tuser = UW'(sent); rb.tlast = (sent == 11);
      end
      step();
      g++;
      if (wr_b) begin sent++; rb.tvalid = 0; end
      if (expon) begin chk("t5_fwd_on", 32'(tb.tvalid), 32'd1); expon = 0; end
      if (used_b == 4'd8 && !saw) begin
        saw = 1; expon = 1;
        chk("t5_full_gate", 32'(tb.tvalid), 32'd0);
      end
    end
    rb.tvalid = 0;
    chk("t5_saw_full", 32'(saw),  32'd1);
    chk("t5_sent",     32'(sent), 32'd12);
    // Forward must have cleared: a new partial packet stays gated
    rb.tvalid = 1; rb.tdata = 8'h61; rb.tuser = 2'd0; rb.tlast = 0;
    step();
    rb.tvalid = 0;
    for (int j = 0; j < 3; j++) begin
      chk("t5_regate", 32'(tb.tvalid), 32'd0);
      step();
    end
    rb.tvalid = 1; rb.tdata = 8'h62; rb.tuser = 2'd1; rb.tlast = 1;
    step();
    rb.tvalid = 0;
    drain();

    // Reset mid-operation discards stored beats
    ta.tready = 1'b0;
    tb.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ra.tvalid = 1; ra.tdata = 8'(8'h70 + i); ra.tuser = UW'(i); ra.tlast = (i == 1 || i == 3);
      step();
    end
    ra.tvalid = 0;
    chk("t6_pre_usedw",   32'(used_a), 32'd5);
    chk("t6_pre_packets", 32'(pk_a),   32'd2);
    areset_n = 1'b0;
    #1;
    chk("t6_usedw",   32'(used_a),    32'd0);
    chk("t6_packets", 32'(pk_a),      32'd0);
    chk("t6_tvalid",  32'(ta.tvalid), 32'd0);
    chk("t6_tready",  32'(ra.tready), 32'd0);
    sba.delete(); sbb.delete();
    m_used_a = 0; m_pk_a = 0; m_used_b = 0; m_pk_b = 0;
    hold_a = 0; hold_b = 0; live = 0;
    step();
    areset_n = 1'b1;
    step();
    ta.tready = 1'b1;
    ra.tvalid = 1; ra.tdata = 8'hC3; ra.tuser = 2'd2; ra.tlast = 1;
    step();
    ra.tvalid = 0;
    chk("t6_n1_tvalid", 32'(ta.tvalid), 32'd0);
    step();
    chk("t6_n2_tvalid", 32'(ta.tvalid), 32'd1);
    chk("t6_n2_tdata",  32'(ta.tdata),  32'hC3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
